debounce_v3: RTL and testbench

Multi-channel button/contact debouncer with a programmable stability threshold, edge-event pulses and long-press detection. Each channel passes through a synchroniser and is sampled on a shared prescaled tick. The output changes only after the new level has been seen on a configurable number of consecutive ticks. The block sits between raw pad inputs and control logic, replacing ad-hoc debouncers plus separate edge detectors.

---
 rtl/debounce_v3.sv | 159 +++++++++++++++
 tb/tb_debounce_v3.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_v3.sv
`timescale 1ns/1ps
// debounce_v3: multi-channel contact debouncer.
// Each raw input is synchronised, sampled on a shared prescaled tick, and
// the debounced level flips only after STABLE_TICKS consecutive ticks at
// the new level. Registered edge pulses (rise/fall) and an optional
// long-press pulse are produced per channel.
//
// Ports:
//   clk         rising-edge clock
//   arst        asynchronous active-high reset
//   ena         clock enable for prescaler, counters and pulses
//   in          raw asynchronous inputs, WIDTH bits
//   out         debounced levels
//   rise/fall   one-cycle pulses coincident with the out change
//   long_press  one-cycle pulse after LONG_TICKS ticks of continuous high out
//
// Per-channel state (no enumerated FSM; the channel state is the pair
// out level / stability count):
//   state                     | meaning
//   out==s, cnt=0             | idle, input agrees with output
//   out!=s, cnt<STABLE_TICKS-1| candidate new level, counting ticks
//   flip                      | last required tick, out takes s, pulse
module debounce_v3 #(
   parameter int WIDTH        = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int PRESCALE     = 16,
   parameter int STABLE_TICKS = 8,
   parameter int LONG_TICKS   = 0,
   parameter int INIT_LEVEL   = 0
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             ena,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] long_press
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int ST_W = $clog2(STABLE_TICKS + 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_TICKS - 1);
   localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
   localparam logic INIT_BIT = (INIT_LEVEL != 0);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("debounce_v3: SYNC_STAGES must be in 2..4");
   end

   // Synchroniser runs every cycle, independent of ena.
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= {WIDTH{INIT_BIT}};
         end
      end else begin
         sync_q[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Shared sample-tick prescaler.
   logic [PS_W-1:0] ps_q;
   logic            tick;

   assign tick = ena && (ps_q == PS_LAST);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ps_q <= '0;
      end else if (tick) begin
         ps_q <= '0;
      end else if (ena) begin
         ps_q <= ps_q + PS_ONE;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic            out_q;
      logic            rise_q;
      logic            fall_q;
      logic            lp_q;
      logic [ST_W-1:0] cnt_q;
      logic            flip;

      // Tick on which out takes the new level.
      assign flip = tick && (s[i] != out_q) && (cnt_q == ST_LAST);

      always_ff @(posedge clk or posedge arst) begin
         if (arst) begin
            out_q  <= INIT_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
               if (s[i] == out_q) begin
                  // Any agreeing tick restarts the window.
                  cnt_q <= '0;
               end else if (cnt_q == ST_LAST) begin
                  out_q  <= s[i];
                  cnt_q  <= '0;
                  rise_q <= s[i];
                  fall_q <= ~s[i];
               end else begin
                  cnt_q <= cnt_q + ST_ONE;
               end
            end
         end
      end

      if (LONG_TICKS > 0) begin : g_long
         localparam int LT_W = $clog2(LONG_TICKS + 1);
         localparam logic [LT_W-1:0] LT_MAX = LT_W'(LONG_TICKS);
         localparam logic [LT_W-1:0] LT_PEN = LT_W'(LONG_TICKS - 1);
         localparam logic [LT_W-1:0] LT_ONE = LT_W'(1);
         logic [LT_W-1:0] hold_q;

         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               hold_q <= '0;
               lp_q   <= 1'b0;
            end else begin
               lp_q <= 1'b0;
               if (tick) begin
                  // Any level change or a low output restarts the hold time.
                  if (flip || !out_q) begin
                     hold_q <= '0;
                  end else if (hold_q != LT_MAX) begin
                     // Saturation at LT_MAX gives one pulse per high period.
                     hold_q <= hold_q + LT_ONE;
                     lp_q   <= (hold_q == LT_PEN);
                  end
               end
            end
         end
      end else begin : g_no_long
         assign lp_q = 1'b0;
      end

      assign out[i]        = out_q;
      assign rise[i]       = rise_q;
      assign fall[i]       = fall_q;
      assign long_press[i] = lp_q;
   end

endmodule

// File: tb/tb_debounce_v3.sv
`timescale 1ns/1ps
module tb_debounce_v3;

   logic       clk = 1'b0;
   logic       arst = 1'b0;
   logic       ena = 1'b1;
   logic [1:0] din = 2'b00;
   logic [1:0] dout, drise, dfall, dlp;

   logic       arst1 = 1'b0;
   logic       ena1 = 1'b1;
   logic [1:0] din1 = 2'b11;
   logic [1:0] dout1, drise1, dfall1, dlp1;

   int checks = 0;
   int failures = 0;

   int rise_cnt0 = 0;
   int fall_cnt0 = 0;
   int lp_cnt0 = 0;
   int tot_pulses = 0;
   int dbl = 0;
   logic [1:0] rise_d = 2'b00, fall_d = 2'b00, lp_d = 2'b00;

   always #5 clk = ~clk;

   debounce_v3 #(
      .WIDTH(2), .SYNC_STAGES(2), .PRESCALE(4), .STABLE_TICKS(3),
      .LONG_TICKS(5), .INIT_LEVEL(0)
   ) u_dut (
      .clk(clk), .arst(arst), .ena(ena), .in(din),
      .out(dout), .rise(drise), .fall(dfall), .long_press(dlp)
   );

   debounce_v3 #(
      .WIDTH(2), .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(1),
      .LONG_TICKS(0), .INIT_LEVEL(1)
   ) u_dut1 (
      .clk(clk), .arst(arst1), .ena(ena1), .in(din1),
      .out(dout1), .rise(drise1), .fall(dfall1), .long_press(dlp1)
   );

   always @(negedge clk) begin
      if (!arst) begin
         if (drise[0]) rise_cnt0 <= rise_cnt0 + 1;
         if (dfall[0]) fall_cnt0 <= fall_cnt0 + 1;
         if (dlp[0])   lp_cnt0   <= lp_cnt0 + 1;
         tot_pulses <= tot_pulses + $countones({drise, dfall, dlp});
         if (((drise & rise_d) | (dfall & fall_d) | (dlp & lp_d)) != 2'b00)
            dbl <= dbl + 1;
      end
      rise_d <= drise;
      fall_d <= dfall;
      lp_d   <= dlp;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int snap;
      time t_rise;

      // Power-on reset
      #1 arst = 1'b1; arst1 = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out", dout, 2'b00);
      check("rst_rise", drise, 2'b00);
      check("rst_fall", dfall, 2'b00);
      check("rst_lp", dlp, 2'b00);
      check("rst_out1", dout1, 2'b11);
      arst = 1'b0; arst1 = 1'b0;

      // Quiet inputs after release
      repeat (100) @(negedge clk);
      check("quiet_pulses", tot_pulses, 0);
      check("quiet_out", dout, 2'b00);
      check("quiet_out1", dout1, 2'b11);

      // Clean step on channel 0
      din[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (dout[0] !== 1'b1 && n < 30);
      t_rise = $time;
      check("step_latency_in_window", 32'(n >= 10 && n <= 15), 1);
      check("step_rise_coincident", drise, 2'b01);
      check("step_fall", dfall, 2'b00);
      @(negedge clk);
      check("step_rise_one_cycle", drise, 2'b00);
      check("step_fall_count", fall_cnt0, 0);

      // Long press
      n = 0;
      do begin @(negedge clk); n++; end while (dlp[0] !== 1'b1 && n < 40);
      check("lp_pulse", dlp, 2'b01);
      check("lp_delay_cycles", 32'(($time - t_rise) / 10), 20);
      repeat (200) @(negedge clk);
      check("lp_no_repeat", lp_cnt0, 1);
      din[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (dfall[0] !== 1'b1 && n < 20);
      check("release_fall", dfall, 2'b01);
      din[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (dlp[0] !== 1'b1 && n < 60);
      check("lp_rearm", dlp, 2'b01);
      @(negedge clk);
      check("lp_count_after_rearm", lp_cnt0, 2);
      din[0] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (dout[0] !== 1'b0 && n < 20);

      // Glitch rejection
      repeat (5) @(negedge clk);
      snap = rise_cnt0;
      din[0] = 1'b1;
      repeat (6) @(negedge clk);
      din[0] = 1'b0;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         din[0] = ~din[0];
         repeat (3) @(negedge clk);
      end
      din[0] = 1'b0;
      repeat (20) @(negedge clk);
      check("glitch_out", dout, 2'b00);
      check("glitch_no_rise", rise_cnt0, snap);

      // Simultaneous channels, ena held high
      din = 2'b10;
      n = 0;
      do begin @(negedge clk); n++; end while (dout !== 2'b10 && n < 30);
      repeat (2) @(negedge clk);
      din = 2'b01;
      n = 0;
      do begin @(negedge clk); n++; end while (drise === 2'b00 && dfall === 2'b00 && n < 40);
      check("simul_latency", n, 14);
      check("simul_rise", drise, 2'b01);
      check("simul_fall", dfall, 2'b10);
      check("simul_out", dout, 2'b01);

      // Same transition with ena low for 50 cycles mid-window
      din = 2'b10;
      n = 0;
      do begin @(negedge clk); n++; end while (dout !== 2'b10 && n < 30);
      repeat (2) @(negedge clk);
      din = 2'b01;
      n = 0;
      repeat (3) begin @(negedge clk); n++; end
      ena = 1'b0;
      repeat (50) begin @(negedge clk); n++; end
      ena = 1'b1;
      do begin @(negedge clk); n++; end while (drise === 2'b00 && dfall === 2'b00 && n < 100);
      check("ena_latency", n, 64);
      check("ena_rise", drise, 2'b01);
      check("ena_fall", dfall, 2'b10);

      // Reset mid-window with out=01 and partial counts
      din = 2'b10;
      repeat (8) @(negedge clk);
      #2 arst = 1'b1;
      #1;
      check("midrst_out", dout, 2'b00);
      check("midrst_rise", drise, 2'b00);
      check("midrst_fall", dfall, 2'b00);
      din = 2'b00;
      @(negedge clk);
      arst = 1'b0;
      snap = tot_pulses;
      repeat (100) @(negedge clk);
      check("postrst_no_pulses", tot_pulses, snap);
      check("postrst_out", dout, 2'b00);

      // INIT_LEVEL=1, STABLE_TICKS=1, PRESCALE=1
      din1 = 2'b00;
      n = 0;
      do begin @(negedge clk); n++; end while (dfall1 === 2'b00 && n < 10);
      check("fast_latency", n, 3);
      check("fast_fall", dfall1, 2'b11);
      check("fast_out", dout1, 2'b00);
      check("fast_rise", drise1, 2'b00);

      check("no_double_pulse", dbl, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
